rgb_fade_seq: RTL and testbench

- Colour sequencer upstream of the RGB PWM comparator stage.
- Holds a 16-entry writable 24-bit palette and steps through entries. Each colour is held, then crossfaded linearly (±1 LSB per channel per step) toward the next.
- Presents a glitch-free 24-bit duty word (R[23:16], G[15:8], B[7:0]) that updates only on the PWM frame boundary, plus the current palette index for the 7-segment display.

---
 rtl/rgb_pkg.sv | 36 +++
 rtl/rgb_step_prescaler.sv | 34 +++
 rtl/rgb_fade_seq.sv | 116 +++++++++++
 tb/tb_rgb_fade_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB colour fade sequencer.
// Channel stepping moves each byte one LSB toward its target.
package rgb_pkg;

  localparam int unsigned PAL_DEPTH = 16;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    StIdle,
    StFade,
    StHold
  } state_e;

  function automatic logic [7:0] step_ch(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) begin
      return cur + 8'd1;
    end else if (cur > tgt) begin
      return cur - 8'd1;
    end
    return cur;
  endfunction

  function automatic rgb_t step_rgb(input rgb_t cur, input rgb_t tgt);
    rgb_t nxt;
    nxt.r = step_ch(cur.r, tgt.r);
    nxt.g = step_ch(cur.g, tgt.g);
    nxt.b = step_ch(cur.b, tgt.b);
    return nxt;
  endfunction

endpackage

// File: rtl/rgb_step_prescaler.sv
// Step-rate prescaler: counts 0..STEP_DIV-1 while enabled, pulses tick on the last count.
// Dropping the enable returns the count to 0 so a restart always begins a full period.
module rgb_step_prescaler #(
  parameter int unsigned STEP_DIV = 156250
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rgb_fade_seq.sv
// Colour sequencer: steps through a writable 16-entry palette, holding and crossfading
// colours, and presents a duty word that only changes on the PWM frame boundary.
module rgb_fade_seq
  import rgb_pkg::*;
#(
  parameter int unsigned STEP_DIV   = 156250,
  parameter int unsigned HOLD_STEPS = 256,
  parameter int unsigned LAST_IDX   = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        frame_sync_i,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_addr_i,
  input  logic [23:0] wr_data_i,
  output logic [23:0] rgb_o,
  output logic [3:0]  idx_o,
  output logic        busy_o,
  output logic        wrap_o
);

  localparam int unsigned HoldW = (HOLD_STEPS > 2) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_STEPS - 1);
  localparam logic [3:0] LastIdx = 4'(LAST_IDX);

  rgb_t             pal_q [PAL_DEPTH];
  rgb_t             cur_q, tgt_q, rgb_q, cur_step;
  logic [3:0]       idx_q, next_idx;
  logic [HoldW-1:0] hold_q;
  state_e           state_q;
  logic             wrap_q, tick;

  rgb_step_prescaler #(
    .STEP_DIV (STEP_DIV)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (run_i && (state_q != StIdle)),
    .tick_o (tick)
  );

  assign next_idx = (idx_q == LastIdx) ? 4'd0 : idx_q + 4'd1;
  assign cur_step = step_rgb(cur_q, tgt_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        pal_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      pal_q[wr_addr_i] <= wr_data_i;
    end
  end

  // tgt is a private copy, so palette writes never disturb a fade already under way.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cur_q   <= '0;
      tgt_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (!run_i) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            tgt_q   <= pal_q[idx_q];
            state_q <= StFade;
          end
          StFade: begin
            if (tick) begin
              cur_q <= cur_step;
              if (cur_step == tgt_q) begin
                state_q <= StHold;
                hold_q  <= '0;
              end
            end
          end
          StHold: begin
            if (tick) begin
              if (hold_q == HoldLast) begin
                idx_q   <= next_idx;
                tgt_q   <= pal_q[next_idx];
                state_q <= StFade;
                wrap_q  <= (idx_q == LastIdx);
              end else begin
                hold_q <= hold_q + HoldW'(1);
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Shadow takes the pre-step colour when a tick lands on the frame boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rgb_q <= '0;
    end else if (frame_sync_i) begin
      rgb_q <= cur_q;
    end
  end

  assign rgb_o  = rgb_q;
  assign idx_o  = idx_q;
  assign busy_o = (state_q == StFade);
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_rgb_fade_seq.sv
// Scoreboard bench for rgb_fade_seq: stimulus queues cycle-stamped expectations,
// a negedge monitor compares each one when its cycle arrives.
module tb_rgb_fade_seq;

  localparam int SelRgb  = 0;
  localparam int SelIdx  = 1;
  localparam int SelBusy = 2;
  localparam int SelWrap = 3;

  typedef struct {
    int          cyc;
    int          sel;
    logic [23:0] val;
    string       name;
  } exp_t;

  logic        clk, rst, run, frame_sync, wr_en;
  logic [3:0]  wr_addr, idx;
  logic [23:0] wr_data, rgb;
  logic        busy, wrap;

  logic        fs_tied, fs_pulse;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          b0, c0;
  logic [23:0] act;
  exp_t        q[$];

  rgb_fade_seq #(
    .STEP_DIV   (4),
    .HOLD_STEPS (2),
    .LAST_IDX   (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .run_i        (run),
    .frame_sync_i (frame_sync),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .rgb_o        (rgb),
    .idx_o        (idx),
    .busy_o       (busy),
    .wrap_o       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame pulse lands on posedges whose count is a multiple of 16.
  initial begin
    frame_sync = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      frame_sync = fs_tied || (fs_pulse && ((cyc % 16) == 15));
    end
  end

  always @(negedge clk) begin
    for (int i = int'(q.size()) - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        case (q[i].sel)
          SelRgb:  act = rgb;
          SelIdx:  act = {20'd0, idx};
          SelBusy: act = {23'd0, busy};
          default: act = {23'd0, wrap};
        endcase
        total++;
        if (q[i].cyc < cyc) begin
          bad++;
          $display("FAIL %s: check at cycle %0d was missed (now %0d)", q[i].name, q[i].cyc, cyc);
        end else if (act !== q[i].val) begin
          bad++;
          $display("FAIL %s @cycle %0d: got %h, expected %h", q[i].name, cyc, act, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_at(input int c, input int sel, input logic [23:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #2;
    wr_en = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    run      = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    fs_tied  = 1'b0;
    fs_pulse = 1'b0;

    expect_at(4, SelRgb,  24'h0, "reset_rgb");
    expect_at(4, SelIdx,  24'h0, "reset_idx");
    expect_at(4, SelBusy, 24'h0, "reset_busy");
    expect_at(4, SelWrap, 24'h0, "reset_wrap");
    wait_to(3);
    rst     = 1'b0;
    fs_tied = 1'b1;

    // Phase B: frame_sync tied high, palette 030100 / 000000 / 000000.
    wait_to(6);
    wr(4'd0, 24'h030100);
    wr(4'd1, 24'h000000);
    wr(4'd2, 24'h000000);
    run = 1'b1;
    b0  = cyc;
    expect_at(b0 + 5,  SelRgb,  24'h000000, "b_pre_tick1");
    expect_at(b0 + 6,  SelRgb,  24'h010100, "b_tick1");
    expect_at(b0 + 10, SelRgb,  24'h020100, "b_tick2");
    expect_at(b0 + 14, SelRgb,  24'h030100, "b_tick3");
    expect_at(b0 + 12, SelBusy, 24'h1,      "b_busy_before_t3");
    expect_at(b0 + 13, SelBusy, 24'h0,      "b_busy_after_t3");
    expect_at(b0 + 20, SelIdx,  24'h0,      "b_idx_before_t5");
    expect_at(b0 + 21, SelIdx,  24'h1,      "b_idx_at_t5");
    expect_at(b0 + 21, SelBusy, 24'h1,      "b_busy_fade1");
    expect_at(b0 + 26, SelRgb,  24'h020000, "b_down1");
    expect_at(b0 + 30, SelRgb,  24'h010000, "b_down2");
    expect_at(b0 + 34, SelRgb,  24'h000000, "b_down3");
    expect_at(b0 + 32, SelBusy, 24'h1,      "b_busy_before_t8");
    expect_at(b0 + 33, SelBusy, 24'h0,      "b_busy_after_t8");
    expect_at(b0 + 41, SelIdx,  24'h2,      "b_idx2");
    expect_at(b0 + 44, SelBusy, 24'h1,      "b_pal2_fade");
    expect_at(b0 + 45, SelBusy, 24'h0,      "b_pal2_hold_first_tick");
    expect_at(b0 + 46, SelRgb,  24'h000000, "b_pal2_rgb");
    expect_at(b0 + 52, SelWrap, 24'h0,      "b_wrap_before");
    expect_at(b0 + 53, SelWrap, 24'h1,      "b_wrap_pulse");
    expect_at(b0 + 54, SelWrap, 24'h0,      "b_wrap_after");
    expect_at(b0 + 52, SelIdx,  24'h2,      "b_idx_before_wrap");
    expect_at(b0 + 53, SelIdx,  24'h0,      "b_idx_wrapped");
    expect_at(b0 + 77, SelIdx,  24'h1,      "b_idx_prereset");
    expect_at(b0 + 77, SelBusy, 24'h1,      "b_busy_prereset");
    expect_at(b0 + 78, SelRgb,  24'h0,      "async_rst_rgb");
    expect_at(b0 + 78, SelIdx,  24'h0,      "async_rst_idx");
    expect_at(b0 + 78, SelBusy, 24'h0,      "async_rst_busy");
    expect_at(b0 + 78, SelWrap, 24'h0,      "async_rst_wrap");

    // Reset asserted between edges while fading 030100 -> 000000.
    wait_to(b0 + 78);
    rst      = 1'b1;
    run      = 1'b0;
    fs_tied  = 1'b0;
    fs_pulse = 1'b1;
    wait_to(b0 + 80);
    rst = 1'b0;

    // Phase C: frame_sync every 16 clocks; pal0 left at its reset value.
    wr(4'd1, 24'h808080);
    wr(4'd2, 24'h808080);
    while ((cyc % 16) != 3) begin
      @(posedge clk);
      #2;
    end
    run = 1'b1;
    c0  = cyc;
    expect_at(c0 + 4,   SelBusy, 24'h1,      "c_pal0_fade");
    expect_at(c0 + 5,   SelBusy, 24'h0,      "c_pal0_reads_zero");
    expect_at(c0 + 12,  SelIdx,  24'h0,      "c_idx0");
    expect_at(c0 + 13,  SelIdx,  24'h1,      "c_idx1");
    expect_at(c0 + 28,  SelRgb,  24'h000000, "c_rgb_held");
    expect_at(c0 + 29,  SelRgb,  24'h030303, "c_fs_tick_prestep1");
    expect_at(c0 + 44,  SelRgb,  24'h030303, "c_rgb_held2");
    expect_at(c0 + 45,  SelRgb,  24'h070707, "c_fs_tick_prestep2");
    expect_at(c0 + 93,  SelRgb,  24'h131313, "c_before_drop");
    expect_at(c0 + 94,  SelBusy, 24'h1,      "c_busy_before_drop");
    expect_at(c0 + 95,  SelBusy, 24'h0,      "c_idle_after_drop");
    expect_at(c0 + 109, SelRgb,  24'h141414, "c_frozen_cur");
    expect_at(c0 + 114, SelBusy, 24'h0,      "c_still_idle");
    expect_at(c0 + 115, SelBusy, 24'h1,      "c_resume_fade");
    expect_at(c0 + 125, SelRgb,  24'h161616, "c_resumed");
    expect_at(c0 + 541, SelRgb,  24'h7e7e7e, "c_near_end");
    expect_at(c0 + 546, SelBusy, 24'h1,      "c_busy_end_before");
    expect_at(c0 + 547, SelBusy, 24'h0,      "c_fade_done");
    expect_at(c0 + 557, SelRgb,  24'h808080, "c_end_808080");
    expect_at(c0 + 566, SelIdx,  24'h2,      "c_idx2");
    expect_at(c0 + 566, SelWrap, 24'h0,      "c_wrap_before");
    expect_at(c0 + 567, SelWrap, 24'h1,      "c_wrap_pulse");
    expect_at(c0 + 567, SelIdx,  24'h0,      "c_idx_wrapped");
    expect_at(c0 + 568, SelWrap, 24'h0,      "c_wrap_after");
    expect_at(c0 + 579, SelIdx,  24'h1,      "c_idx1_again");
    expect_at(c0 + 589, SelRgb,  24'h828282, "c_new_ffffff_used");

    wait_to(c0 + 94);
    run = 1'b0;
    wait_to(c0 + 114);
    run = 1'b1;
    // Overwrite the active entry mid-fade; it takes effect only on the next loop.
    wait_to(c0 + 200);
    wr(4'd1, 24'hffffff);
    wr(4'd0, 24'h808080);
    wait_to(c0 + 600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
